dmac_xfer_ctrl: RTL and testbench
=================================

Name: dmac_xfer_ctrl

Overview:
Single-channel DMA transfer sequencer. It moves a programmed number of 32-bit words from a source address to a destination address over a shared bus master port, using the channel FIFO as a staging buffer. Each burst reads up to BURST words into the FIFO, then drains the FIFO to the destination. It sits between the DMAC register slave (start, addresses, size), the bus arbiter (req/grant) and the FIFO (wr_en, rd_en, data_count).

Parameters:
BURST, 4, max words read into the FIFO per burst; BURST ≤ DEPTH
DEPTH, 16, FIFO depth in words; fifo_data_count == DEPTH means full

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that launches a transfer; ignored unless IDLE
src_addr  input  32  source start address, word-aligned
dest_addr  input  32  destination start address, word-aligned
size  input  8  transfer length in words, 0..255
irq_clr  input  1  clears irq
m_grant  input  1  bus grant from arbiter
m_din  input  32  bus read data, valid in the same cycle as a granted read address
m_req  output  1  bus request
m_wr  output  1  1 = write cycle, 0 = read cycle
m_addr  output  32  bus address
m_dout  output  32  bus write data
fifo_wr_en  output  1  FIFO push
fifo_din  output  32  FIFO push data (= m_din)
fifo_rd_en  output  1  FIFO pop
fifo_dout  input  32  FIFO head word, first-word-fall-through
fifo_data_count  input  5  FIFO occupancy, 0..DEPTH
busy  output  1  1 in any state except IDLE
op_done  output  1  one-cycle pulse at end of transfer
irq  output  1  sticky completion flag

Behaviour:
- Reset (synchronous, active-high): state = IDLE. m_req, m_wr, fifo_wr_en, fifo_rd_en, busy, op_done and irq are 0. m_addr, m_dout and all internal pointers/counters are 0. Reset mid-transfer abandons the transfer at the next edge. This block does not flush the FIFO; the FIFO shares the same reset.
- States: IDLE, REQ, RD, WR, DONE. Registered state; outputs are decoded from state plus inputs.
- IDLE:
  - On start with size != 0: latch src_ptr = src_addr, dst_ptr = dest_addr, rd_rem = size, wr_rem = size; go to REQ.
  - On start with size == 0: go to DONE.
- REQ: m_req = 1. On m_grant, clear burst_cnt and go to RD.
- RD: m_req = 1, m_wr = 0, m_addr = src_ptr, fifo_din = m_din.
  - Each cycle with m_grant = 1 and fifo_data_count < DEPTH: fifo_wr_en = 1, src_ptr += 4, rd_rem -= 1, burst_cnt += 1.
  - Leave to WR after the transferring cycle in which burst_cnt reaches BURST or rd_rem reaches 0.
- WR: m_req = 1, m_wr = 1, m_addr = dst_ptr, m_dout = fifo_dout.
  - Each cycle with m_grant = 1 and fifo_data_count != 0: fifo_rd_en = 1, dst_ptr += 4, wr_rem -= 1.
  - After the pop where fifo_data_count == 1 (FIFO drained): go to DONE if wr_rem becomes 0, else go to REQ.
- DONE: op_done = 1 for exactly one cycle, irq set to 1, busy = 1; next state IDLE.
- Grant loss: if m_grant = 0 in RD or WR, stall. No FIFO strobe, no pointer or counter change; state holds until grant returns.
- Guards:
  - fifo_wr_en is never asserted when fifo_data_count == DEPTH.
  - fifo_rd_en is never asserted when fifo_data_count == 0.
  - fifo_wr_en and fifo_rd_en are never asserted in the same cycle.
- Arithmetic: pointers wrap modulo 2^32. Counters are 8 bits and never decrement below 0.
- irq: set in DONE, cleared by irq_clr. If set and clear coincide, set wins. Cleared by reset.
- start while busy = 1 is ignored; latched parameters are unchanged.

Test Plan:
- reset, start with src=0x100, dest=0x200, size=3, grant tied 1 -> bus reads 0x100/0x104/0x108, then writes 0x200/0x204/0x208 with matching data; op_done pulses once; irq=1; 8 cycles from start to DONE.
- size=10, BURST=4, grant tied 1 -> bursts of 4, 4, 2 reads, each followed by an equal number of writes; dest receives 10 words in order; FIFO count peaks at 4.
- size=5, drop m_grant for 3 cycles mid-RD and 2 cycles mid-WR -> no strobes or address changes during the gaps; final data is intact; DONE is delayed by exactly 5 cycles.
- start with size=0 -> DONE on the next cycle, op_done=1, no m_req; irq=1; irq_clr pulse -> irq=0; irq_clr in the DONE cycle -> irq stays 1.
- assert reset while in WR with wr_rem=6 -> next cycle IDLE, all outputs 0; a new start (size=2) completes normally.
- start pulse while busy with different addresses -> ignored; the original transfer completes to the original addresses.

Source files
------------

// File: rtl/dmac_xfer_ctrl_if.sv
// Signal bundle between the DMA transfer sequencer and its register slave, bus arbiter and FIFO.
// The sequencer is the bus master; the surrounding environment connects through the slave modport.
interface dmac_xfer_ctrl_if;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dest_addr;
  logic [7:0]  size;
  logic        irq_clr;
  logic        m_grant;
  logic [31:0] m_din;
  logic        m_req;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_dout;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout;
  logic [4:0]  fifo_data_count;
  logic        busy;
  logic        op_done;
  logic        irq;

  modport master (
    input  start, src_addr, dest_addr, size, irq_clr, m_grant, m_din, fifo_dout, fifo_data_count,
    output m_req, m_wr, m_addr, m_dout, fifo_wr_en, fifo_din, fifo_rd_en, busy, op_done, irq
  );

  modport slave (
    output start, src_addr, dest_addr, size, irq_clr, m_grant, m_din, fifo_dout, fifo_data_count,
    input  m_req, m_wr, m_addr, m_dout, fifo_wr_en, fifo_din, fifo_rd_en, busy, op_done, irq
  );
endinterface

// File: rtl/dmac_xfer_ctrl.sv
// Single-channel DMA sequencer: reads bursts of up to BURST words into the channel FIFO,
// then drains the FIFO to the destination, until the programmed word count has moved.
module dmac_xfer_ctrl #(
  parameter int unsigned BURST = 4,
  parameter int unsigned DEPTH = 16
) (
  input logic             i_clk,
  input logic             i_reset,
  dmac_xfer_ctrl_if.master io_dma
);

  typedef enum logic [2:0] {StIdle, StReq, StRd, StWr, StDone} state_e;

  localparam logic [4:0] LpDepth = 5'(DEPTH);
  localparam logic [7:0] LpBurst = 8'(BURST);

  state_e      r_state;
  logic [31:0] r_src_ptr;
  logic [31:0] r_dst_ptr;
  logic [7:0]  r_rd_rem;
  logic [7:0]  r_wr_rem;
  logic [7:0]  r_burst_cnt;
  logic        r_irq;

  logic        w_rd_xfer;
  logic        w_wr_xfer;
  logic [7:0]  w_rd_rem_nxt;
  logic [7:0]  w_wr_rem_nxt;
  logic [7:0]  w_burst_nxt;

  // A word moves only when granted and the FIFO has room (read) or data (write).
  always_comb begin
    w_rd_xfer    = (r_state == StRd) && io_dma.m_grant && (io_dma.fifo_data_count < LpDepth);
    w_wr_xfer    = (r_state == StWr) && io_dma.m_grant && (io_dma.fifo_data_count != 5'd0);
    w_rd_rem_nxt = (r_rd_rem != 8'd0) ? r_rd_rem - 8'd1 : 8'd0;
    w_wr_rem_nxt = (r_wr_rem != 8'd0) ? r_wr_rem - 8'd1 : 8'd0;
    w_burst_nxt  = r_burst_cnt + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_src_ptr   <= 32'd0;
      r_dst_ptr   <= 32'd0;
      r_rd_rem    <= 8'd0;
      r_wr_rem    <= 8'd0;
      r_burst_cnt <= 8'd0;
      r_irq       <= 1'b0;
    end else begin
      // Completion beats a coincident clear.
      if (r_state == StDone) begin
        r_irq <= 1'b1;
      end else if (io_dma.irq_clr) begin
        r_irq <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (io_dma.start) begin
            if (io_dma.size != 8'd0) begin
              r_src_ptr <= io_dma.src_addr;
              r_dst_ptr <= io_dma.dest_addr;
              r_rd_rem  <= io_dma.size;
              r_wr_rem  <= io_dma.size;
              r_state   <= StReq;
            end else begin
              r_state <= StDone;
            end
          end
        end
        StReq: begin
          if (io_dma.m_grant) begin
            r_burst_cnt <= 8'd0;
            r_state     <= StRd;
          end
        end
        StRd: begin
          if (w_rd_xfer) begin
            r_src_ptr   <= r_src_ptr + 32'd4;
            r_rd_rem    <= w_rd_rem_nxt;
            r_burst_cnt <= w_burst_nxt;
            if ((w_burst_nxt == LpBurst) || (w_rd_rem_nxt == 8'd0)) begin
              r_state <= StWr;
            end
          end
        end
        StWr: begin
          if (w_wr_xfer) begin
            r_dst_ptr <= r_dst_ptr + 32'd4;
            r_wr_rem  <= w_wr_rem_nxt;
            // Popping the last staged word ends the burst.
            if (io_dma.fifo_data_count == 5'd1) begin
              r_state <= (w_wr_rem_nxt == 8'd0) ? StDone : StReq;
            end
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    io_dma.m_req      = (r_state == StReq) || (r_state == StRd) || (r_state == StWr);
    io_dma.m_wr       = (r_state == StWr);
    io_dma.m_addr     = 32'd0;
    io_dma.m_dout     = 32'd0;
    if (r_state == StRd) begin
      io_dma.m_addr = r_src_ptr;
    end else if (r_state == StWr) begin
      io_dma.m_addr = r_dst_ptr;
      io_dma.m_dout = io_dma.fifo_dout;
    end
    io_dma.fifo_din   = io_dma.m_din;
    io_dma.fifo_wr_en = w_rd_xfer;
    io_dma.fifo_rd_en = w_wr_xfer;
    io_dma.busy       = (r_state != StIdle);
    io_dma.op_done    = (r_state == StDone);
    io_dma.irq        = r_irq;
  end

endmodule

// File: tb/tb_dmac_xfer_ctrl.sv
// Randomised scoreboard bench for dmac_xfer_ctrl with a behavioural FIFO, source memory and
// transfer model; a negedge monitor checks every bus strobe against queued expectations.
module tb_dmac_xfer_ctrl;
  localparam int BURST = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   start_cyc = -1000;
  int   grant_mode = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_exp_done = 0;
  int   peak = 0;
  bit   saw_req = 0;

  logic [31:0] exp_ra[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];

  logic [31:0] fifo_mem[DEPTH];
  logic [3:0]  fifo_rp;
  logic [3:0]  fifo_wp;
  logic [4:0]  fifo_cnt;

  dmac_xfer_ctrl_if u_if ();

  dmac_xfer_ctrl #(
    .BURST(BURST),
    .DEPTH(DEPTH)
  ) u_dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_dma (u_if)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Cycles from the start cycle to the DONE cycle with an uninterrupted grant.
  function automatic int exp_latency(input int n);
    int lat;
    int rem;
    int b;
    lat = 1;
    rem = n;
    while (rem > 0) begin
      b = (rem < BURST) ? rem : BURST;
      lat += 1 + 2 * b;
      rem -= b;
    end
    return lat;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural first-word-fall-through FIFO sharing the DUT reset.
  always @(posedge clk) begin
    if (rst) begin
      fifo_rp  <= 4'd0;
      fifo_wp  <= 4'd0;
      fifo_cnt <= 5'd0;
    end else begin
      if (u_if.fifo_wr_en) begin
        fifo_mem[fifo_wp] <= u_if.fifo_din;
        fifo_wp <= fifo_wp + 4'd1;
      end
      if (u_if.fifo_rd_en) fifo_rp <= fifo_rp + 4'd1;
      fifo_cnt <= fifo_cnt + 5'(u_if.fifo_wr_en) - 5'(u_if.fifo_rd_en);
    end
  end

  assign u_if.fifo_dout       = fifo_mem[fifo_rp];
  assign u_if.fifo_data_count = fifo_cnt;
  assign u_if.m_din           = mem_word(u_if.m_addr);

  // Grant: tied high, random, or scripted gaps relative to the start cycle.
  initial begin
    int k;
    u_if.m_grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k = cyc - start_cyc;
      case (grant_mode)
        1:       u_if.m_grant = ($urandom_range(0, 99) < 70);
        2:       u_if.m_grant = !(k inside {3, 4, 5, 10, 11});
        default: u_if.m_grant = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes the FIFO or signals completion.
  initial begin
    logic wr;
    logic rd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr = u_if.fifo_wr_en;
        rd = u_if.fifo_rd_en;
        if (u_if.m_req) saw_req = 1'b1;
        if (int'(u_if.fifo_data_count) > peak) peak = int'(u_if.fifo_data_count);
        if (wr || rd) chk("strobe_excl", 32'(wr & rd), 32'd0);
        if (!u_if.m_grant && u_if.busy) chk("stall_strobe", 32'(wr | rd), 32'd0);
        if (wr) begin
          chk("wr_when_full", 32'(u_if.fifo_data_count == 5'(DEPTH)), 32'd0);
          chk("rd_cycle_mwr", 32'(u_if.m_wr), 32'd0);
          chk("rd_extra", 32'(exp_ra.size() == 0), 32'd0);
          if (exp_ra.size() != 0) chk("rd_addr", u_if.m_addr, exp_ra.pop_front());
        end
        if (rd) begin
          chk("rd_when_empty", 32'(u_if.fifo_data_count == 5'd0), 32'd0);
          chk("wr_cycle_mwr", 32'(u_if.m_wr), 32'd1);
          chk("wr_extra", 32'(exp_wa.size() == 0), 32'd0);
          if (exp_wa.size() != 0) begin
            chk("wr_addr", u_if.m_addr, exp_wa.pop_front());
            chk("wr_data", u_if.m_dout, exp_wd.pop_front());
          end
        end
        if (u_if.op_done) begin
          chk("done_extra", 32'(n_exp_done == 0), 32'd0);
          if (n_exp_done > 0) n_exp_done--;
          chk("done_rd_left", 32'(exp_ra.size()), 32'd0);
          chk("done_wr_left", 32'(exp_wa.size()), 32'd0);
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                       input bit expect_it);
    u_if.start     = 1'b1;
    u_if.src_addr  = s;
    u_if.dest_addr = d;
    u_if.size      = n;
    if (expect_it) begin
      start_cyc = cyc;
      for (int i = 0; i < int'(n); i++) begin
        exp_ra.push_back(s + 32'(4 * i));
        exp_wa.push_back(d + 32'(4 * i));
        exp_wd.push_back(mem_word(s + 32'(4 * i)));
      end
      n_exp_done++;
    end
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound && lat < 0; i++) begin
      @(negedge clk);
      if (u_if.op_done) lat = cyc - start_cyc;
    end
    chk("done_seen", 32'(lat >= 0), 32'd1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(u_if.op_done), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] s;
    logic [31:0] d;
    rst = 1'b1;
    u_if.start = 1'b0;
    u_if.src_addr = '0;
    u_if.dest_addr = '0;
    u_if.size = '0;
    u_if.irq_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {25'd0, u_if.busy, u_if.m_req, u_if.m_wr, u_if.fifo_wr_en,
                        u_if.fifo_rd_en, u_if.op_done, u_if.irq}, 32'd0);
    chk("reset_addr", u_if.m_addr, 32'd0);
    chk("reset_dout", u_if.m_dout, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(32'h100, 32'h200, 8'd3, 1'b1);
    wait_done(100, lat);
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_irq", 32'(u_if.irq), 32'd1);

    peak = 0;
    issue(32'h400, 32'h800, 8'd10, 1'b1);
    wait_done(200, lat);
    chk("t2_latency", 32'(lat), 32'(exp_latency(10)));
    chk("t2_peak", 32'(peak), 32'd4);

    grant_mode = 2;
    issue(32'h1000, 32'h2000, 8'd5, 1'b1);
    wait_done(200, lat);
    chk("t3_latency", 32'(lat), 32'(exp_latency(5) + 5));
    grant_mode = 0;

    u_if.irq_clr = 1'b1;
    @(posedge clk);
    #1;
    u_if.irq_clr = 1'b0;
    chk("irq_cleared", 32'(u_if.irq), 32'd0);
    saw_req = 1'b0;
    issue(32'h7000, 32'h7100, 8'd0, 1'b1);
    wait_done(20, lat);
    chk("size0_latency", 32'(lat), 32'd1);
    chk("size0_no_req", 32'(saw_req), 32'd0);
    chk("size0_irq", 32'(u_if.irq), 32'd1);
    u_if.irq_clr = 1'b1;
    @(posedge clk);
    #1;
    u_if.irq_clr = 1'b0;
    chk("irq_clr_pulse", 32'(u_if.irq), 32'd0);
    issue(32'h7000, 32'h7100, 8'd0, 1'b1);
    u_if.irq_clr = 1'b1;
    @(posedge clk);
    #1;
    u_if.irq_clr = 1'b0;
    chk("irq_set_wins", 32'(u_if.irq), 32'd1);

    issue(32'h9000, 32'hA000, 8'd8, 1'b1);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    chk("mid_wr_left", 32'(exp_wa.size()), 32'd6);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_flags", {25'd0, u_if.busy, u_if.m_req, u_if.m_wr, u_if.fifo_wr_en,
                         u_if.fifo_rd_en, u_if.op_done, u_if.irq}, 32'd0);
    chk("midrst_addr", u_if.m_addr, 32'd0);
    exp_ra.delete();
    exp_wa.delete();
    exp_wd.delete();
    n_exp_done = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'hB000, 32'hC000, 8'd2, 1'b1);
    wait_done(100, lat);
    chk("after_rst_latency", 32'(lat), 32'(exp_latency(2)));

    issue(32'h3000, 32'h4000, 8'd6, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    issue(32'h5000, 32'h6000, 8'd9, 1'b0);
    wait_done(200, lat);
    chk("busy_start_latency", 32'(lat), 32'(exp_latency(6)));
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_ignored", 32'(u_if.busy), 32'd0);

    grant_mode = 1;
    for (int t = 0; t < 25; t++) begin
      n = (t % 8 == 0) ? 0 : (t % 11 == 5) ? int'($urandom_range(100, 255))
                                            : int'($urandom_range(1, 3 * BURST + 1));
      s = {$urandom(), 2'b00};
      d = {$urandom(), 2'b00};
      if (t % 6 == 3) s = 32'hFFFF_FFF8;
      issue(s, d, 8'(n), 1'b1);
      repeat ($urandom_range(0, 6)) begin
        @(posedge clk);
        #1;
      end
      if (u_if.busy) issue(~s, ~d, 8'($urandom_range(1, 255)), 1'b0);
      for (int i = 0; i < 30 + 12 * n && n_exp_done != 0; i++) @(posedge clk);
      #1;
      chk("rand_done", 32'(n_exp_done), 32'd0);
      chk("rand_idle", 32'(u_if.busy), 32'd0);
    end
    grant_mode = 0;

    repeat (2) @(posedge clk);
    chk("end_rd_left", 32'(exp_ra.size()), 32'd0);
    chk("end_wr_left", 32'(exp_wa.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
